dmem_bus_bridge: RTL and testbench

//  Sits directly downstream of the data memory controller, on its early-strobe data bus.

---
 rtl/dmem_bus_bridge_pkg.sv | 17 +
 rtl/dmem_write_buffer.sv | 50 +++++
 rtl/dmem_bus_bridge.sv | 169 ++++++++++++++++
 tb/tb_dmem_bus_bridge.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_bridge_pkg.sv
// Shared definitions for the data-memory bus bridge: bus widths, FSM states,
// and the default read data returned on a bus timeout.
package dmem_bus_bridge_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BUS_AW = 30;
   localparam int unsigned BE_W   = 4;

   localparam logic [DATA_W-1:0] DEF_ERROR_DATA = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      DMB_IDLE,
      DMB_RD,
      DMB_WR_DRAIN
   } dmb_state_e;

endpackage

// File: rtl/dmem_write_buffer.sv
// Single-entry posted-write buffer: filled on load, emptied when the bus
// acknowledges (or times out) the drain of the held entry.
module dmem_write_buffer
   import dmem_bus_bridge_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              drain_ack,
   input  logic [BUS_AW-1:0] addr_in,
   input  logic [BE_W-1:0]   be_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              full,
   output logic [BUS_AW-1:0] addr,
   output logic [BE_W-1:0]   be,
   output logic [DATA_W-1:0] data
);

   logic              full_q, full_d;
   logic [BUS_AW-1:0] addr_q, addr_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      full_d = load | (full_q & ~drain_ack);
      addr_d = load ? addr_in : addr_q;
      be_d   = load ? be_in   : be_q;
      data_d = load ? data_in : data_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         full_q <= 1'b0;
         addr_q <= '0;
         be_q   <= '0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         addr_q <= addr_d;
         be_q   <= be_d;
         data_q <= data_d;
      end
   end

   assign full = full_q;
   assign addr = addr_q;
   assign be   = be_q;
   assign data = data_q;

endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges M-stage data accesses onto a req/ack external bus, posting stores
// through a one-entry write buffer and stalling M until reads return.
module dmem_bus_bridge
   import dmem_bus_bridge_pkg::*;
#(
   parameter bit            WB_ENABLE      = 1'b1,
   parameter int unsigned   TIMEOUT_CYCLES = 255,
   parameter int unsigned   TIMEOUT_WIDTH  = 8,
   parameter logic [31:0]   ERROR_DATA     = DEF_ERROR_DATA
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] Mem_EarlyAddress,
   input  logic        Mem_EarlyWrite,
   input  logic        Mem_EarlyStrobe,
   input  logic [31:0] Mem_Address,
   input  logic [31:0] Mem_WriteData,
   input  logic        Mem_Write,
   input  logic [3:0]  Mem_ByteSelect,
   output logic        Mem_Stall,
   output logic [31:0] Mem_ReadData,
   output logic        Bus_Request,
   output logic        Bus_Write,
   output logic [29:0] Bus_Address,
   output logic [3:0]  Bus_ByteSelect,
   output logic [31:0] Bus_WriteData,
   input  logic        Bus_Ack,
   input  logic [31:0] Bus_ReadData,
   output logic        Bus_Error
);

   localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   dmb_state_e state_q, state_d;

   logic                     pend_q, pend_d, pend_wr_q, pend_wr_d;
   logic [BUS_AW-1:0]        pend_addr_q, pend_addr_d;
   logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [DATA_W-1:0]        rd_data_q, rd_data_d;
   logic                     bus_req_q, bus_req_d, bus_wr_q, bus_wr_d, bus_err_q, bus_err_d;
   logic [BUS_AW-1:0]        bus_addr_q, bus_addr_d;
   logic [BE_W-1:0]          bus_be_q, bus_be_d;
   logic [DATA_W-1:0]        bus_wdata_q, bus_wdata_d;

   logic              wb_load, wb_drain_ack, wb_full, wb_full_next;
   logic [BUS_AW-1:0] wb_addr;
   logic [BE_W-1:0]   wb_be;
   logic [DATA_W-1:0] wb_data;
   logic              tmo, done, rd_done, wr_access, wr_clear, pend_clear;
   logic              strobe_rd, rd_next, issue;
   logic              unused_addr_lsbs;

   assign unused_addr_lsbs = ^{Mem_Address[1:0], Mem_EarlyAddress[1:0]};

   dmem_write_buffer u_wbuf (
      .clock     (clock),
      .reset     (reset),
      .load      (wb_load),
      .drain_ack (wb_drain_ack),
      .addr_in   (Mem_Address[31:2]),
      .be_in     (Mem_ByteSelect),
      .data_in   (Mem_WriteData),
      .full      (wb_full),
      .addr      (wb_addr),
      .be        (wb_be),
      .data      (wb_data)
   );

   // A timeout is handled exactly like an ack; only the read data differs.
   always_comb begin
      tmo          = bus_req_q & ~Bus_Ack & (tmo_cnt_q == TMO_LAST);
      done         = bus_req_q & (Bus_Ack | tmo);
      rd_done      = done & (state_q == DMB_RD);
      wb_drain_ack = done & (state_q == DMB_WR_DRAIN);
      wr_access    = pend_q & pend_wr_q;
      wb_load      = wr_access & Mem_Write & ~wb_full;
      wb_full_next = wb_load | (wb_full & ~wb_drain_ack);
      strobe_rd    = Mem_EarlyStrobe & ~Mem_EarlyWrite;
      rd_next      = strobe_rd | (pend_q & ~pend_wr_q & ~rd_done);

      // Without the buffer a store stays pending until its own drain completes.
      if (WB_ENABLE) wr_clear = wb_load | ~Mem_Write;
      else           wr_clear = (~Mem_Write & ~wb_full) | wb_drain_ack;

      pend_clear  = pend_wr_q ? wr_clear : rd_done;
      pend_d      = (pend_q & ~pend_clear) | Mem_EarlyStrobe;
      pend_wr_d   = Mem_EarlyStrobe ? Mem_EarlyWrite : pend_wr_q;
      pend_addr_d = Mem_EarlyStrobe ? Mem_EarlyAddress[31:2] : pend_addr_q;

      tmo_cnt_d = (bus_req_q & ~Bus_Ack & ~tmo) ? tmo_cnt_q + TIMEOUT_WIDTH'(1) : '0;
      rd_data_d = rd_done ? (Bus_Ack ? Bus_ReadData : ERROR_DATA) : rd_data_q;
      bus_err_d = tmo;
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= DMB_IDLE;
      else       state_q <= state_d;
   end

   // Buffered stores always go out before a waiting read.
   always_comb begin
      state_d = state_q;
      if (state_q == DMB_IDLE || done) begin
         if (wb_full_next)  state_d = DMB_WR_DRAIN;
         else if (rd_next)  state_d = DMB_RD;
         else               state_d = DMB_IDLE;
      end
   end

   always_comb begin
      issue       = (state_d != DMB_IDLE) & ((state_q == DMB_IDLE) | done);
      bus_req_d   = (state_d != DMB_IDLE);
      bus_wr_d    = bus_wr_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      if (issue) begin
         if (state_d == DMB_RD) begin
            bus_wr_d    = 1'b0;
            bus_addr_d  = strobe_rd ? Mem_EarlyAddress[31:2] : pend_addr_q;
            bus_be_d    = '1;
            bus_wdata_d = '0;
         end else begin
            bus_wr_d    = 1'b1;
            bus_addr_d  = wb_load ? Mem_Address[31:2] : wb_addr;
            bus_be_d    = wb_load ? Mem_ByteSelect    : wb_be;
            bus_wdata_d = wb_load ? Mem_WriteData     : wb_data;
         end
      end
      Mem_Stall = (pend_q & ~pend_wr_q) | (wr_access & Mem_Write & (WB_ENABLE ? wb_full : 1'b1));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pend_q      <= 1'b0;
         pend_wr_q   <= 1'b0;
         pend_addr_q <= '0;
         tmo_cnt_q   <= '0;
         rd_data_q   <= '0;
         bus_req_q   <= 1'b0;
         bus_wr_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         pend_q      <= pend_d;
         pend_wr_q   <= pend_wr_d;
         pend_addr_q <= pend_addr_d;
         tmo_cnt_q   <= tmo_cnt_d;
         rd_data_q   <= rd_data_d;
         bus_req_q   <= bus_req_d;
         bus_wr_q    <= bus_wr_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign Mem_ReadData   = rd_data_q;
   assign Bus_Request    = bus_req_q;
   assign Bus_Write      = bus_wr_q;
   assign Bus_Address    = bus_addr_q;
   assign Bus_ByteSelect = bus_be_q;
   assign Bus_WriteData  = bus_wdata_q;
   assign Bus_Error      = bus_err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: expected bus transactions are queued as
// stimulus is applied and popped on every acknowledged bus cycle.
module tb_dmem_bus_bridge;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] Mem_EarlyAddress, Mem_Address, Mem_WriteData, Mem_ReadData;
   logic        Mem_EarlyWrite, Mem_EarlyStrobe, Mem_Write, Mem_Stall;
   logic [3:0]  Mem_ByteSelect, Bus_ByteSelect;
   logic        Bus_Request, Bus_Write, Bus_Ack, Bus_Error;
   logic [29:0] Bus_Address;
   logic [31:0] Bus_WriteData, Bus_ReadData;

   int unsigned passes = 0;
   int unsigned fails  = 0;
   int unsigned total  = 0;
   logic [66:0] exp_q[$];
   int          k;

   dmem_bus_bridge #(
      .WB_ENABLE      (1'b1),
      .TIMEOUT_CYCLES (255),
      .TIMEOUT_WIDTH  (8),
      .ERROR_DATA     (32'hFFFF_FFFF)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .Mem_EarlyAddress (Mem_EarlyAddress),
      .Mem_EarlyWrite   (Mem_EarlyWrite),
      .Mem_EarlyStrobe  (Mem_EarlyStrobe),
      .Mem_Address      (Mem_Address),
      .Mem_WriteData    (Mem_WriteData),
      .Mem_Write        (Mem_Write),
      .Mem_ByteSelect   (Mem_ByteSelect),
      .Mem_Stall        (Mem_Stall),
      .Mem_ReadData     (Mem_ReadData),
      .Bus_Request      (Bus_Request),
      .Bus_Write        (Bus_Write),
      .Bus_Address      (Bus_Address),
      .Bus_ByteSelect   (Bus_ByteSelect),
      .Bus_WriteData    (Bus_WriteData),
      .Bus_Ack          (Bus_Ack),
      .Bus_ReadData     (Bus_ReadData),
      .Bus_Error        (Bus_Error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic wr, input logic [31:0] byte_addr, input logic [3:0] be,
                       input logic [31:0] data);
      exp_q.push_back({wr, byte_addr[31:2], be, wr ? data : 32'h0});
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // Sample point: strobe legality plus scoreboard pop on each acked bus cycle.
   task automatic mid();
      logic [66:0] obs;
      @(negedge clock);
      if (Mem_EarlyStrobe) chk("strobe_while_stalled", 67'(Mem_Stall), 67'(0));
      if (!reset && Bus_Request && Bus_Ack) begin
         obs = {Bus_Write, Bus_Address, Bus_ByteSelect, Bus_Write ? Bus_WriteData : 32'h0};
         if (exp_q.size() == 0) begin
            total++;
            fails++;
            $error("FAIL bus_unexpected: observed %h expected none", obs);
         end else begin
            chk("bus_txn", obs, exp_q.pop_front());
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      Mem_EarlyAddress = '0; Mem_EarlyWrite = 1'b0; Mem_EarlyStrobe = 1'b0;
      Mem_Address = '0; Mem_WriteData = '0; Mem_Write = 1'b0; Mem_ByteSelect = '0;
      Bus_Ack = 1'b0; Bus_ReadData = 32'h0BAD_0BAD;
      repeat (2) next_cycle();
      mid();
      chk("rst_req",   67'(Bus_Request), 67'(0));
      chk("rst_wr",    67'(Bus_Write), 67'(0));
      chk("rst_addr",  67'(Bus_Address), 67'(0));
      chk("rst_be",    67'(Bus_ByteSelect), 67'(0));
      chk("rst_wdata", 67'(Bus_WriteData), 67'(0));
      chk("rst_err",   67'(Bus_Error), 67'(0));
      chk("rst_stall", 67'(Mem_Stall), 67'(0));
      chk("rst_rdata", 67'(Mem_ReadData), 67'(0));
      next_cycle(); reset = 1'b0;
      mid();

      // 1: read acked in its first bus cycle
      next_cycle();
      Mem_EarlyStrobe = 1'b1; Mem_EarlyWrite = 1'b0; Mem_EarlyAddress = 32'h0000_1004;
      push(1'b0, 32'h0000_1004, 4'hF, 32'h0);
      mid();
      chk("t1_no_req_yet", 67'(Bus_Request), 67'(0));
      next_cycle();
      Mem_EarlyStrobe = 1'b0; Mem_Address = 32'h0000_1004;
      Bus_Ack = 1'b1; Bus_ReadData = 32'hCAFE_F00D;
      mid();
      chk("t1_req",   67'(Bus_Request), 67'(1));
      chk("t1_addr",  67'(Bus_Address), 67'(30'h401));
      chk("t1_stall", 67'(Mem_Stall), 67'(1));
      next_cycle();
      Bus_Ack = 1'b0; Bus_ReadData = 32'h0BAD_0BAD;
      mid();
      chk("t1_stall_rel", 67'(Mem_Stall), 67'(0));
      chk("t1_rdata",     67'(Mem_ReadData), 67'(32'hCAFE_F00D));
      chk("t1_req_drop",  67'(Bus_Request), 67'(0));

      // 2: posted write followed by a read to the same word
      next_cycle();
      Mem_EarlyStrobe = 1'b1; Mem_EarlyWrite = 1'b1; Mem_EarlyAddress = 32'h0000_2000;
      mid();
      next_cycle();
      Mem_EarlyStrobe = 1'b1; Mem_EarlyWrite = 1'b0; Mem_EarlyAddress = 32'h0000_2000;
      Mem_Address = 32'h0000_2000; Mem_Write = 1'b1; Mem_ByteSelect = 4'hF;
      Mem_WriteData = 32'h1234_5678;
      push(1'b1, 32'h0000_2000, 4'hF, 32'h1234_5678);
      push(1'b0, 32'h0000_2000, 4'hF, 32'h0);
      mid();
      chk("t2_wr_nostall", 67'(Mem_Stall), 67'(0));
      next_cycle();
      Mem_EarlyStrobe = 1'b0; Mem_Write = 1'b0;
      mid();
      chk("t2_drain_req", 67'({Bus_Request, Bus_Write}), 67'(2'b11));
      chk("t2_rd_stall",  67'(Mem_Stall), 67'(1));
      next_cycle(); Bus_Ack = 1'b1;
      mid();
      chk("t2_stall_ack", 67'(Mem_Stall), 67'(1));
      next_cycle(); Bus_Ack = 1'b0;
      mid();
      chk("t2_rd_req",   67'({Bus_Request, Bus_Write}), 67'(2'b10));
      chk("t2_stall_rd", 67'(Mem_Stall), 67'(1));
      next_cycle(); Bus_Ack = 1'b1; Bus_ReadData = 32'hA5A5_0001;
      mid();
      next_cycle(); Bus_Ack = 1'b0; Bus_ReadData = 32'h0BAD_0BAD;
      mid();
      chk("t2_stall_rel", 67'(Mem_Stall), 67'(0));
      chk("t2_rdata",     67'(Mem_ReadData), 67'(32'hA5A5_0001));

      // 3: back-to-back stores with a slow bus
      next_cycle();
      Mem_EarlyStrobe = 1'b1; Mem_EarlyWrite = 1'b1; Mem_EarlyAddress = 32'h0000_3000;
      mid();
      next_cycle();
      Mem_EarlyAddress = 32'h0000_3004;
      Mem_Address = 32'h0000_3000; Mem_Write = 1'b1; Mem_ByteSelect = 4'hF;
      Mem_WriteData = 32'h1111_1111;
      push(1'b1, 32'h0000_3000, 4'hF, 32'h1111_1111);
      mid();
      chk("t3_w1_nostall", 67'(Mem_Stall), 67'(0));
      next_cycle();
      Mem_EarlyStrobe = 1'b0;
      Mem_Address = 32'h0000_3004; Mem_ByteSelect = 4'b0011; Mem_WriteData = 32'h2222_2222;
      push(1'b1, 32'h0000_3004, 4'b0011, 32'h2222_2222);
      mid();
      chk("t3_w2_stall", 67'(Mem_Stall), 67'(1));
      chk("t3_w1_addr",  67'(Bus_Address), 67'(30'hC00));
      repeat (2) begin
         next_cycle();
         mid();
         chk("t3_w2_hold", 67'(Mem_Stall), 67'(1));
      end
      next_cycle(); Bus_Ack = 1'b1;
      mid();
      chk("t3_stall_ack", 67'(Mem_Stall), 67'(1));
      next_cycle(); Bus_Ack = 1'b0;
      mid();
      chk("t3_capture_nostall", 67'(Mem_Stall), 67'(0));
      chk("t3_req_gap",         67'(Bus_Request), 67'(0));
      next_cycle(); Mem_Write = 1'b0;
      mid();
      chk("t3_w2_req", 67'({Bus_Request, Bus_Write, Bus_ByteSelect}), 67'(6'b11_0011));
      next_cycle(); Bus_Ack = 1'b1;
      mid();
      next_cycle(); Bus_Ack = 1'b0;
      mid();
      chk("t3_req_drop", 67'(Bus_Request), 67'(0));

      // 4: store squashed in M, then 5: a read the bus never acknowledges
      next_cycle();
      Mem_EarlyStrobe = 1'b1; Mem_EarlyWrite = 1'b1; Mem_EarlyAddress = 32'h0000_4000;
      mid();
      next_cycle();
      Mem_EarlyStrobe = 1'b0; Mem_Address = 32'h0000_4000; Mem_Write = 1'b0;
      mid();
      chk("t4_stall", 67'(Mem_Stall), 67'(0));
      chk("t4_req",   67'(Bus_Request), 67'(0));
      next_cycle();
      Mem_EarlyStrobe = 1'b1; Mem_EarlyWrite = 1'b0; Mem_EarlyAddress = 32'h0000_5008;
      mid();
      chk("t4_still_idle", 67'(Bus_Request), 67'(0));
      next_cycle();
      Mem_EarlyStrobe = 1'b0; Mem_Address = 32'h0000_5008;
      mid();
      chk("t5_req",   67'({Bus_Request, Bus_Write}), 67'(2'b10));
      chk("t5_addr",  67'(Bus_Address), 67'(30'h1402));
      chk("t5_stall", 67'(Mem_Stall), 67'(1));
      k = 0;
      while (!Bus_Error && k < 400) begin
         next_cycle();
         mid();
         k++;
      end
      chk("t5_err_cycle", 67'(k), 67'(255));
      chk("t5_req_drop",  67'(Bus_Request), 67'(0));
      chk("t5_rdata",     67'(Mem_ReadData), 67'(32'hFFFF_FFFF));
      chk("t5_stall_rel", 67'(Mem_Stall), 67'(0));
      next_cycle();
      mid();
      chk("t5_err_pulse", 67'(Bus_Error), 67'(0));

      // 6: reset while a read waits for its ack
      next_cycle();
      Mem_EarlyStrobe = 1'b1; Mem_EarlyWrite = 1'b0; Mem_EarlyAddress = 32'h0000_6000;
      mid();
      next_cycle();
      Mem_EarlyStrobe = 1'b0; Mem_Address = 32'h0000_6000; reset = 1'b1;
      mid();
      chk("t6_req_before", 67'(Bus_Request), 67'(1));
      next_cycle();
      reset = 1'b0; Bus_Ack = 1'b1; Bus_ReadData = 32'hDEAD_BEEF;
      mid();
      chk("t6_req",   67'(Bus_Request), 67'(0));
      chk("t6_stall", 67'(Mem_Stall), 67'(0));
      next_cycle(); Bus_Ack = 1'b0; Bus_ReadData = 32'h0BAD_0BAD;
      mid();
      chk("t6_late_ack_ignored", 67'(Mem_ReadData), 67'(0));
      chk("t6_idle",             67'(Bus_Request), 67'(0));

      chk("sb_empty", 67'(exp_q.size()), 67'(0));
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
